// File: rtl/pipe_add_pkg.sv
// Shared constants, helpers and per-stage control record for the pipelined
// carry-lookahead adder.
package pipe_add_pkg;

   localparam int unsigned CLA_GROUP = 4;

   function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
      return width / seg;
   endfunction

   // Control part of each stage payload; the sum-so-far and remaining operands
   // are width-dependent and live next to it in the stage register.
   typedef struct packed {
      logic valid;
      logic carry;
   } stage_ctrl_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG-bit carry-lookahead adder built from 4-bit generate/propagate
// groups; the group carries are chained, never rippled through full adders.
module cla_segment
   import pipe_add_pkg::*;
#(
   parameter int unsigned SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           msb_cin
);

   localparam int unsigned NGRP = SEG / CLA_GROUP;

   logic [CLA_GROUP-1:0] g;
   logic [CLA_GROUP-1:0] p;
   logic [CLA_GROUP-1:0] c;
   logic                 carry;

   always_comb begin
      sum     = '0;
      cout    = 1'b0;
      msb_cin = 1'b0;
      g       = '0;
      p       = '0;
      c       = '0;
      carry   = cin;
      for (int j = 0; j < int'(NGRP); j++) begin
         g    = a[j*CLA_GROUP +: CLA_GROUP] & b[j*CLA_GROUP +: CLA_GROUP];
         p    = a[j*CLA_GROUP +: CLA_GROUP] ^ b[j*CLA_GROUP +: CLA_GROUP];
         c[0] = carry;
         c[1] = g[0] | (p[0] & carry);
         c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
         c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
         sum[j*CLA_GROUP +: CLA_GROUP] = p ^ c;
         // the last group's c[3] is the carry into the segment MSB
         msb_cin = c[3];
         carry   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | ((&p) & carry);
      end
      cout = carry;
   end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage,
// latency NSEG, valid/ready flow control. Optional out_ovf via PIPE_ADD_OVF_EN.
module pipelined_cla_adder
   import pipe_add_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPE_ADD_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int unsigned NSEG = nseg(WIDTH, SEG);

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;
   assign b_eff    = in_sub ? ~in_b : in_b;
   assign cin_eff  = in_sub | in_cin;

   // Stage k payload layout: {b_rem, a_rem, sum[k*SEG-1:0]}; each stage consumes
   // the low SEG bits of the remaining operands and appends one sum slice.
   for (genvar k = 0; k < int'(NSEG); k++) begin : g_stage
      localparam int unsigned IN_W = WIDTH - k*SEG;
      localparam int unsigned LO   = k*SEG;
      localparam int unsigned PW   = 2*IN_W + LO;
      localparam int unsigned DW   = PW - SEG;
      localparam int unsigned REM  = IN_W - SEG;

      logic [PW-1:0]  p;
      logic           c_prev;
      logic           v_prev;
      logic [SEG-1:0] seg_sum;
      logic           seg_cout;
      logic           seg_msb_unused;
      logic [DW-1:0]  d_next;
      logic [DW-1:0]  d_q;
      stage_ctrl_t    ctrl_q;

      if (k == 0) begin : g_src
         assign p      = {b_eff, in_a};
         assign c_prev = cin_eff;
         assign v_prev = in_valid;
      end else begin : g_src
         assign p      = g_stage[k-1].d_q;
         assign c_prev = g_stage[k-1].ctrl_q.carry;
         assign v_prev = g_stage[k-1].ctrl_q.valid;
      end

      cla_segment #(.SEG(SEG)) u_seg (
         .a       (p[LO +: SEG]),
         .b       (p[LO + IN_W +: SEG]),
         .cin     (c_prev),
         .sum     (seg_sum),
         .cout    (seg_cout),
         .msb_cin (seg_msb_unused)
      );

      always_comb begin
         d_next = '0;
         for (int i = 0; i < int'(LO); i++) d_next[i] = p[i];
         d_next[LO +: SEG] = seg_sum;
         for (int i = 0; i < int'(REM); i++) begin
            d_next[LO + SEG + i]       = p[LO + SEG + i];
            d_next[LO + SEG + REM + i] = p[LO + IN_W + SEG + i];
         end
      end

      // Whole pipeline shifts or holds together, bubbles included.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ctrl_q <= '0;
            d_q    <= '0;
         end else if (adv) begin
            ctrl_q.valid <= v_prev;
            ctrl_q.carry <= seg_cout;
            d_q          <= d_next;
         end
      end

`ifdef PIPE_ADD_OVF_EN
      if (k == int'(NSEG) - 1) begin : g_ovf
         logic ovf_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)      ovf_q <= 1'b0;
            else if (adv) ovf_q <= seg_msb_unused ^ seg_cout;
         end
      end
`endif
   end

   assign out_valid = g_stage[NSEG-1].ctrl_q.valid;
   assign out_cout  = g_stage[NSEG-1].ctrl_q.carry;
   assign out_sum   = g_stage[NSEG-1].d_q;
`ifdef PIPE_ADD_OVF_EN
   assign out_ovf   = g_stage[NSEG-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (32/8 main instance, 16/16 single-stage).
module tb_pipelined_cla_adder;

   localparam int unsigned W    = 32;
   localparam int          NSEG = 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
`ifdef PIPE_ADD_OVF_EN
      logic         ovf;
`endif
      int           t;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, in_cin, in_sub;
   logic [W-1:0] in_a, in_b;
   logic         out_valid, out_ready, out_cout;
   logic [W-1:0] out_sum;

   logic         one_in_valid, one_in_ready, one_in_cin, one_in_sub;
   logic [15:0]  one_in_a, one_in_b, one_out_sum;
   logic         one_out_valid, one_out_ready, one_out_cout;
`ifdef PIPE_ADD_OVF_EN
   logic         out_ovf, one_out_ovf, last_ovf;
`endif

   exp_t         sb[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           n_out = 0;
   logic         acc, check_lat, hold_pending;
   logic [W-1:0] hold_sum, last_sum;
   logic         hold_cout, last_cout;

   always #5 clk = ~clk;

   pipelined_cla_adder #(.WIDTH(32), .SEG(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef PIPE_ADD_OVF_EN
      , .out_ovf(out_ovf)
`endif
   );

   pipelined_cla_adder #(.WIDTH(16), .SEG(16)) dut_one (
      .clk(clk), .rst(rst),
      .in_valid(one_in_valid), .in_ready(one_in_ready), .in_a(one_in_a), .in_b(one_in_b),
      .in_cin(one_in_cin), .in_sub(one_in_sub),
      .out_valid(one_out_valid), .out_ready(one_out_ready), .out_sum(one_out_sum),
      .out_cout(one_out_cout)
`ifdef PIPE_ADD_OVF_EN
      , .out_ovf(one_out_ovf)
`endif
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      exp_t         m;
      logic [W-1:0] be;
      logic [W:0]   r;
      be = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, be} + (W+1)'(sub ? 1'b1 : cin);
      m.sum  = r[W-1:0];
      m.cout = r[W];
`ifdef PIPE_ADD_OVF_EN
      m.ovf  = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
`endif
      m.t    = cyc;
      return m;
   endfunction

   // One cycle: sample settled handshakes after the negedge drive, then advance.
   task automatic tick();
      exp_t e;
      #1;
      acc = in_valid & in_ready;
      if (hold_pending) begin
         total++;
         if (out_valid !== 1'b1 || out_sum !== hold_sum || out_cout !== hold_cout) begin
            bad++;
            $display("FAIL stall_hold: valid=%b sum=%h cout=%b, required valid=1 sum=%h cout=%b",
                     out_valid, out_sum, out_cout, hold_sum, hold_cout);
         end
      end
      hold_pending = 1'b0;
      if (acc) sb.push_back(model(in_a, in_b, in_cin, in_sub));
      if (out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: sum=%h cout=%b, required no result", out_sum, out_cout);
         end else begin
            e = sb.pop_front();
            if (out_sum !== e.sum || out_cout !== e.cout) begin
               bad++;
               $display("FAIL result: sum=%h cout=%b, required sum=%h cout=%b",
                        out_sum, out_cout, e.sum, e.cout);
            end
`ifdef PIPE_ADD_OVF_EN
            total++;
            if (out_ovf !== e.ovf) begin
               bad++;
               $display("FAIL ovf: got %b, required %b", out_ovf, e.ovf);
            end
`endif
            if (check_lat) begin
               total++;
               if (cyc - e.t != NSEG) begin
                  bad++;
                  $display("FAIL latency: got %0d, required %0d", cyc - e.t, NSEG);
               end
            end
         end
         last_sum  = out_sum;
         last_cout = out_cout;
`ifdef PIPE_ADD_OVF_EN
         last_ovf  = out_ovf;
`endif
         n_out++;
      end else if (out_valid) begin
         hold_pending = 1'b1;
         hold_sum     = out_sum;
         hold_cout    = out_cout;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
      int n0;
      n0 = n_out;
      out_ready = 1'b1;
      drive(a, b, cin, sub);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && n_out == n0; i++) tick();
      total++;
      if (n_out == n0) begin
         bad++;
         $display("FAIL op_timeout: outputs=%0d, required %0d", n_out, n0 + 1);
      end
   endtask

   task automatic test_reset();
      #1;
      total++;
      if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: valid=%b sum=%h cout=%b ready=%b, required 0 0 0 1",
                  out_valid, out_sum, out_cout, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_wrap();
      check_lat = 1'b1;
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      total++;
      if (last_sum !== 32'h0000_0000 || last_cout !== 1'b1) begin
         bad++;
         $display("FAIL add_wrap: sum=%h cout=%b, required 00000000 1", last_sum, last_cout);
      end
      run_op(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      total++;
      if (last_sum !== 32'h0001_0000 || last_cout !== 1'b0) begin
         bad++;
         $display("FAIL add_cin: sum=%h cout=%b, required 00010000 0", last_sum, last_cout);
      end
   endtask

   task automatic test_sub();
      check_lat = 1'b1;
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
      total++;
      if (last_sum !== 32'hFFFF_FFFE || last_cout !== 1'b0) begin
         bad++;
         $display("FAIL sub_borrow: sum=%h cout=%b, required fffffffe 0", last_sum, last_cout);
      end
      run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
      total++;
      if (last_sum !== 32'h0000_0002 || last_cout !== 1'b1) begin
         bad++;
         $display("FAIL sub_noborrow: sum=%h cout=%b, required 00000002 1", last_sum, last_cout);
      end
   endtask

`ifdef PIPE_ADD_OVF_EN
   task automatic test_ovf();
      run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      total++;
      if (last_ovf !== 1'b1 || last_sum !== 32'h8000_0000) begin
         bad++;
         $display("FAIL ovf_add: ovf=%b sum=%h, required 1 80000000", last_ovf, last_sum);
      end
      run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      total++;
      if (last_ovf !== 1'b1 || last_sum !== 32'h7FFF_FFFF) begin
         bad++;
         $display("FAIL ovf_sub: ovf=%b sum=%h, required 1 7fffffff", last_ovf, last_sum);
      end
   endtask
`endif

   task automatic test_back_to_back();
      int n0;
      n0 = n_out;
      check_lat = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(W'(i) * 32'h1357_9BDF, 32'hF0F0_0F0F ^ W'(i), 1'(i), 1'(i >> 1));
         tick();
         total++;
         if (acc !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: op %0d accepted=%b, required 1", i, acc);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      total++;
      if (n_out - n0 != 8) begin
         bad++;
         $display("FAIL b2b_count: got %0d, required 8", n_out - n0);
      end
   endtask

   task automatic test_random_stall();
      int n0, sent;
      n0 = n_out;
      sent = 0;
      check_lat = 1'b0;
      drive($urandom, $urandom, 1'($urandom), 1'($urandom));
      for (int g = 0; g < 400 && sent < 16; g++) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         if (acc) begin
            sent++;
            if (sent % 4 == 0) drive(32'hFFFF_FFFF, $urandom, 1'b1, 1'b0);
            else               drive($urandom, $urandom, 1'($urandom), 1'($urandom));
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int g = 0; g < 40 && sb.size() != 0; g++) tick();
      total++;
      if (n_out - n0 != 16 || sb.size() != 0) begin
         bad++;
         $display("FAIL stream_count: got %0d pending %0d, required 16 pending 0",
                  n_out - n0, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(32'h1000_0000 + W'(i), 32'h0000_0100, 1'b0, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      tick();
      #1;
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_valid: got %b, required 1", out_valid);
      end
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_sum !== '0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_flush: valid=%b sum=%h ready=%b, required 0 0 1",
                  out_valid, out_sum, in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      hold_pending = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_after_reset: cycle %0d valid=%b, required 0", i, out_valid);
         end
      end
   endtask

   task automatic test_single_stage();
      one_in_a = 16'h1234; one_in_b = 16'h4321; one_in_cin = 1'b0; one_in_sub = 1'b0;
      one_in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (one_out_valid !== 1'b1 || one_out_sum !== 16'h5555 || one_out_cout !== 1'b0) begin
         bad++;
         $display("FAIL single_add: valid=%b sum=%h cout=%b, required 1 5555 0",
                  one_out_valid, one_out_sum, one_out_cout);
      end
      one_in_a = 16'h0001; one_in_b = 16'h0002; one_in_sub = 1'b1;
      @(negedge clk);
      total++;
      if (one_out_valid !== 1'b1 || one_out_sum !== 16'hFFFF || one_out_cout !== 1'b0) begin
         bad++;
         $display("FAIL single_sub: valid=%b sum=%h cout=%b, required 1 ffff 0",
                  one_out_valid, one_out_sum, one_out_cout);
      end
      one_in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (one_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL single_bubble: valid=%b, required 0", one_out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
      one_in_valid = 1'b0; one_in_a = '0; one_in_b = '0; one_in_cin = 1'b0;
      one_in_sub = 1'b0; one_out_ready = 1'b1;
      check_lat = 1'b0; hold_pending = 1'b0; acc = 1'b0;
      hold_sum = '0; hold_cout = 1'b0; last_sum = '0; last_cout = 1'b0;
`ifdef PIPE_ADD_OVF_EN
      last_ovf = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_add_wrap();
      test_sub();
`ifdef PIPE_ADD_OVF_EN
      test_ovf();
`endif
      test_back_to_back();
      test_random_stall();
      test_reset_mid();
      test_single_stage();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
